// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master issues operands; the slave returns the difference and flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH:0]   sum_in;
    logic [WIDTH-1:0] in1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             underflow;
    logic             overflow;

    modport master (
        output start, sum_in, in1,
        input  busy, done, diff, underflow, overflow
    );

    modport slave (
        input  start, sum_in, in1,
        output busy, done, diff, underflow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = sum_in - in1 over WIDTH+1 bits.
// One bit per clock, start/busy/done handshake, results held until next done.
module serial_subtractor #(
    parameter int WIDTH = 10
) (
    input logic              clk,
    input logic              rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             brw_q, brw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             uf_q, uf_d;
    logic             of_q, of_d;
    logic             abit, bbit;

    assign abit = a_q[0];
    assign bbit = b_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        uf_d    = uf_q;
        of_d    = of_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.sum_in;
                    b_d     = {1'b0, bus.in1};
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Each difference bit enters at the MSB so the LSB ends at bit 0
                res_d = {abit ^ bbit ^ brw_q, res_q[WIDTH:1]};
                brw_d = (~abit & bbit) | (~(abit ^ bbit) & brw_q);
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = S_FIN;
            end
            S_FIN: begin
                diff_d  = res_q[WIDTH-1:0];
                uf_d    = brw_q;
                of_d    = ~brw_q & res_q[WIDTH];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            uf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            uf_q    <= uf_d;
            of_q    <= of_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.diff      = diff_q;
    assign bus.underflow = uf_q;
    assign bus.overflow  = of_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepted requests queue their
// arithmetic expectation; a monitor checks every done pulse against it.
module tb_serial_subtractor;
    localparam int W   = 10;
    localparam int LAT = 12;

    logic clk;
    logic rst_n;

    serial_subtractor_if #(.WIDTH(W)) bus();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int s;
        int a;
        int t;
        int ed;
        bit euf;
        bit eof;
    } op_t;

    op_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  ndone = 0;
    int  npush = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction reduced to WIDTH+1 bits
    function automatic op_t model(input int s, input int a, input int t);
        op_t o;
        int  d;
        d     = s - a;
        o.s   = s;
        o.a   = a;
        o.t   = t;
        o.euf = (s < a);
        o.ed  = ((d % 2048) + 2048) % 1024;
        o.eof = !o.euf && (d >= 1024);
        return o;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.start && !bus.busy) begin
            q.push_back(model(int'(bus.sum_in), int'(bus.in1), cyc));
            npush++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy && bus.done) chk("busy_and_done", 1, 0);
            if (bus.done) begin
                ndone++;
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    op_t o;
                    o = q.pop_front();
                    chk("diff", int'(bus.diff), o.ed);
                    chk("underflow", int'(bus.underflow), int'(o.euf));
                    chk("overflow", int'(bus.overflow), int'(o.eof));
                    chk("latency", cyc - o.t - 1, LAT);
                end
            end else if (q.size() > 0 && !bus.busy) begin
                chk("busy_while_pending", 0, 1);
            end else if (q.size() == 0 && bus.busy) begin
                chk("busy_when_idle", 1, 0);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        chk("drain_timeout", q.size(), 0);
        q.delete();
    endtask

    task automatic run_op(input int s, input int a);
        int d0;
        d0 = ndone;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.sum_in = 11'(s);
        bus.in1    = 10'(a);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.sum_in = 11'($urandom);
        bus.in1    = 10'($urandom);
        drain();
        chk("one_done", ndone - d0, 1);
    endtask

    initial begin
        int d0;
        int p0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.sum_in = '0;
        bus.in1    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_uf", int'(bus.underflow), 0);
        chk("rst_of", int'(bus.overflow), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_done", int'(bus.done), 0);

        run_op(30, 10);
        run_op(579, 123);
        run_op(5, 10);
        run_op(2046, 0);
        run_op(1023, 1023);
        run_op(0, 1023);
        run_op(2047, 0);
        run_op(1024, 0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
        end

        // Start held high with operands churning every cycle
        d0 = ndone;
        p0 = npush;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 65; i++) begin
            bus.sum_in = 11'($urandom);
            bus.in1    = 10'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("held_accepts", npush - p0, 5);
        drain();
        chk("held_dones", ndone - d0, 5);

        // Abort mid-operation
        @(negedge clk);
        bus.start  = 1'b1;
        bus.sum_in = 11'd30;
        bus.in1    = 10'd10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        d0 = ndone;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_diff", int'(bus.diff), 0);
        chk("abort_uf", int'(bus.underflow), 0);
        chk("abort_of", int'(bus.overflow), 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", ndone - d0, 0);
        run_op(579, 123);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule
